qpsk_symbol_scheduler: RTL and testbench

//   Sequences the conventional QPSK modulator. Accepts a serial bitstream over a valid/ready

---
 rtl/qpsk_symbol_scheduler.sv | 81 ++++++++
 tb/tb_qpsk_symbol_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_scheduler.sv
// qpsk_symbol_scheduler: buffers a serial bitstream and issues one (E,O) QPSK symbol per carrier period
module qpsk_symbol_scheduler #(
  parameter int SPS        = 100,
  parameter int PH_W       = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             enable,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             E,
  output logic             O,
  output logic [PH_W-1:0]  phase,
  output logic             mod_en,
  output logic             sym_strobe,
  output logic             underrun,
  output logic [LVL_W-1:0] fifo_level
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state;
  // Shift-style buffer: bit 0 is always the oldest, so a pop is a shift by two.
  logic [2**LVL_W-1:0] fifo, fifo_nxt;
  logic [LVL_W-1:0] wr_idx;
  logic push, pop, sym_end;
  assign bit_ready = fifo_level != LVL_W'(FIFO_DEPTH);
  assign push      = bit_valid && bit_ready;
  assign sym_end   = state == RUN && phase == PH_W'(SPS - 1);
  assign pop       = enable && fifo_level >= LVL_W'(2) && (state == PRIME || sym_end);
  assign wr_idx    = pop ? fifo_level - LVL_W'(2) : fifo_level;
  always_comb begin
    fifo_nxt = pop ? fifo >> 2 : fifo;
    if (push) fifo_nxt[wr_idx] = bit_in;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      fifo       <= '0;
      fifo_level <= '0;
    end else begin
      fifo       <= fifo_nxt;
      fifo_level <= fifo_level + LVL_W'(push) - (pop ? LVL_W'(2) : LVL_W'(0));
    end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state      <= IDLE;
      E          <= 1'b0;
      O          <= 1'b0;
      phase      <= '0;
      mod_en     <= 1'b0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
      if (pop) begin
        E          <= fifo[0];
        O          <= fifo[1];
        phase      <= '0;
        mod_en     <= 1'b1;
        sym_strobe <= 1'b1;
        state      <= RUN;
      end else begin
        case (state)
          IDLE:  if (enable) state <= PRIME;
          PRIME: if (!enable) state <= IDLE;
          RUN:
            if (!sym_end) phase <= phase + PH_W'(1);
            else begin
              // Symbol boundary without a pop: stop if disabled, otherwise underrun.
              phase    <= '0;
              mod_en   <= 1'b0;
              underrun <= enable;
              state    <= enable ? PRIME : IDLE;
            end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// tb_qpsk_symbol_scheduler: directed stimulus with a bit-queue scoreboard checked at every strobe
module tb_qpsk_symbol_scheduler;
  localparam int SPS = 100;
  logic Clk = 1'b0, Rst_n = 1'b0, enable = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic bit_ready, E, O, mod_en, sym_strobe, underrun;
  logic [6:0] phase;
  logic [3:0] fifo_level;
  int checks = 0, errors = 0, strobes = 0, len = 0, s0;
  bit in_sym = 0;
  bit sb[$];

  qpsk_symbol_scheduler dut (
    .Clk(Clk), .Rst_n(Rst_n), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .E(E), .O(O), .phase(phase), .mod_en(mod_en),
    .sym_strobe(sym_strobe), .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 Clk = ~Clk;

  function automatic void chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_bit(input bit b);
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  // Scoreboard: accepted bits queued in order, popped in pairs at each strobe.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      sb.delete();
      in_sym = 0;
      len = 0;
    end else begin
      if (sym_strobe) begin
        if (in_sym) chk("sym_len", len, SPS);
        if (sb.size() >= 2) begin
          chk("E", int'(E), int'(sb.pop_front()));
          chk("O", int'(O), int'(sb.pop_front()));
        end else chk("sb_bits", sb.size(), 2);
        len = 1;
        in_sym = 1;
        strobes++;
      end else if (mod_en) len++;
      else if (in_sym) begin
        chk("sym_len", len, SPS);
        in_sym = 0;
      end
      if (mod_en) chk("phase", int'(phase), len - 1);
      chk("level", int'(fifo_level), sb.size());
      chk("strobe_and_underrun", int'(sym_strobe && underrun), 0);
      if (bit_valid && bit_ready) sb.push_back(bit_in);
    end
  end

  initial begin
    tick();
    chk("rst_E", int'(E), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_mod_en", int'(mod_en), 0);
    chk("rst_level", int'(fifo_level), 0);
    Rst_n = 1'b1;
    tick();
    // T2: two back-to-back symbols then underrun
    enable = 1'b1;
    push_bit(1); push_bit(0); push_bit(1); push_bit(1);
    for (int i = 0; i < 400 && !underrun; i++) tick();
    chk("t2_underrun", int'(underrun), 1);
    chk("t2_strobes", strobes, 2);
    chk("t2_mod_en", int'(mod_en), 0);
    chk("t2_level", int'(fifo_level), 0);
    // T4: graceful stop mid-symbol (state is PRIME, so pushes alone start a symbol)
    s0 = strobes;
    for (int i = 0; i < 4; i++) push_bit(1'($urandom_range(0, 1)));
    for (int i = 0; i < 200 && !(mod_en && phase == 7'd37); i++) tick();
    chk("t4_phase37", int'(phase), 37);
    enable = 1'b0;
    for (int i = 0; i < 200 && mod_en; i++) tick();
    chk("t4_mod_en", int'(mod_en), 0);
    chk("t4_phase", int'(phase), 0);
    chk("t4_level", int'(fifo_level), 2);
    chk("t4_no_underrun", int'(underrun), 0);
    chk("t4_strobes", strobes - s0, 1);
    // T5: push on the wrap cycle while exactly two bits are buffered
    push_bit(0); push_bit(1);
    enable = 1'b1;
    for (int i = 0; i < 300 && !(mod_en && phase == 7'd99); i++) tick();
    chk("t5_level_at_99", int'(fifo_level), 2);
    push_bit(1);
    chk("t5_strobe", int'(sym_strobe), 1);
    chk("t5_level", int'(fifo_level), 1);
    // T6: odd remainder waits for one more bit
    for (int i = 0; i < 300 && !underrun; i++) tick();
    chk("t6_underrun", int'(underrun), 1);
    chk("t6_level", int'(fifo_level), 1);
    repeat (5) tick();
    chk("t6_level_hold", int'(fifo_level), 1);
    chk("t6_mute", int'(mod_en), 0);
    push_bit(0);
    for (int i = 0; i < 10 && !sym_strobe; i++) tick();
    chk("t6_strobe", int'(sym_strobe), 1);
    chk("t6_level0", int'(fifo_level), 0);
    for (int i = 0; i < 300 && !underrun; i++) tick();
    chk("t6_underrun2", int'(underrun), 1);
    // T3: backpressure while idle
    enable = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) push_bit(1'($urandom_range(0, 1)));
    chk("t3_ready", int'(bit_ready), 0);
    chk("t3_level8", int'(fifo_level), 8);
    push_bit(1);
    chk("t3_level_full", int'(fifo_level), 8);
    enable = 1'b1;
    for (int i = 0; i < 10 && !mod_en; i++) tick();
    chk("t3_mod_en", int'(mod_en), 1);
    chk("t3_level6", int'(fifo_level), 6);
    // T1: asynchronous reset mid-symbol
    for (int i = 0; i < 200 && !(mod_en && phase == 7'd50); i++) tick();
    chk("t1_phase50", int'(phase), 50);
    #2 Rst_n = 1'b0;
    #1;
    chk("t1_mod_en", int'(mod_en), 0);
    chk("t1_phase", int'(phase), 0);
    chk("t1_EO", int'({E, O}), 0);
    chk("t1_flags", int'({sym_strobe, underrun}), 0);
    chk("t1_level", int'(fifo_level), 0);
    tick();
    Rst_n = 1'b1;
    tick();
    chk("t1_ready", int'(bit_ready), 1);
    chk("t1_level_after", int'(fifo_level), 0);
    push_bit(0); push_bit(1);
    for (int i = 0; i < 10 && !sym_strobe; i++) tick();
    chk("t1_restart", int'(sym_strobe), 1);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
